adder_stim_gen: RTL

//  Stimulus source that sits directly upstream of the adder DUV/ref_adder pair in the adder benches.

---
 rtl/adder_stim_gen.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/adder_stim_gen.sv
// adder_stim_gen: on-chip stimulus source for the adder benches.
// It sends six fixed corner vectors first. It then sends pseudo-random vectors built from a
// 32-bit LFSR. Each vector {a, b, cin} is offered on a valid/ready handshake, and the run stops
// after NUM_VECTORS transfers.

module adder_stim_gen #(
    parameter int          N           = 128,
    parameter int          NUM_VECTORS = 30000,
    parameter logic [31:0] SEED        = 32'h0000_0001
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic         ready,
    output logic         valid,
    output logic [N-1:0] a,
    output logic [N-1:0] b,
    output logic         cin,
    output logic [31:0]  vec_idx,
    output logic         busy,
    output logic         done
);

    // 32-bit words per operand. Filling a/b takes 2*WORDS words, plus one more word for cin.
    localparam int WORDS       = N / 32;
    localparam int FILL_CYCLES = 2 * WORDS + 1;
    localparam int FW          = $clog2(FILL_CYCLES);

    localparam logic [FW-1:0] FILL_LAST   = FW'(FILL_CYCLES - 1);
    localparam logic [31:0]   SEED_EFF    = (SEED == 32'd0) ? 32'd1 : SEED;
    localparam logic [31:0]   LAST_IDX    = 32'(NUM_VECTORS - 1);
    localparam logic [31:0]   LAST_CORNER = 32'd5;
    localparam bit            EMPTY_RUN   = (NUM_VECTORS == 0);

    typedef enum logic [2:0] {
        IDLE,
        CORNER,
        FILL,
        PRESENT,
        DONE
    } state_t;

    typedef struct packed {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         cin;
    } vec_t;

    // Fixed corner-case vectors C0..C5. Wide patterns are truncated or replicated to N bits.
    function automatic vec_t corner_vec(input logic [2:0] k);
        vec_t v;
        v = '0;
        case (k)
            3'd0: v = '0;
            3'd1: begin
                v.a   = '1;
                v.cin = 1'b1;
            end
            3'd2: begin
                v.a   = '1;
                v.b   = '1;
                v.cin = 1'b1;
            end
            3'd3: begin
                v.a   = {(N/2){2'b01}};
                v.b   = {(N/2){2'b10}};
                v.cin = 1'b1;
            end
            3'd4: begin
                v.a = N'(1);
                v.b = '1;
            end
            3'd5: begin
                v.a = {1'b1, {(N-1){1'b0}}};
                v.b = {1'b1, {(N-1){1'b0}}};
            end
            default: v = '0;
        endcase
        return v;
    endfunction

    // One Fibonacci LFSR step with taps 31, 21, 1 and 0.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    state_t          state, state_next;
    logic [31:0]     lfsr, lfsr_next;
    logic [2*N-1:0]  shift, shift_next;
    logic [FW-1:0]   fill_cnt, fill_next;
    logic            valid_next, cin_next, busy_next, done_next;
    logic [N-1:0]    a_next, b_next;
    logic [31:0]     idx_next;
    logic            xfer;
    logic [31:0]     word;
    vec_t            cv;

    // Next-state and next-output logic for the whole generator.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        state_next = state;
        lfsr_next  = lfsr;
        shift_next = shift;
        fill_next  = fill_cnt;
        valid_next = valid;
        a_next     = a;
        b_next     = b;
        cin_next   = cin;
        idx_next   = vec_idx;
        busy_next  = busy;
        done_next  = done;
        xfer       = valid && ready;
        word       = lfsr_step(lfsr);
        cv         = corner_vec(vec_idx[2:0] + 3'd1);

        if (abort && state != IDLE) begin
            // Abort takes priority over a transfer in the same cycle. The pending vector is dropped.
            state_next = IDLE;
            valid_next = 1'b0;
            busy_next  = 1'b0;
            done_next  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        lfsr_next = SEED_EFF;
                        idx_next  = '0;
                        fill_next = '0;
                        if (EMPTY_RUN) begin
                            state_next = DONE;
                            busy_next  = 1'b0;
                            done_next  = 1'b1;
                        end else begin
                            state_next = CORNER;
                            busy_next  = 1'b1;
                            done_next  = 1'b0;
                            valid_next = 1'b1;
                            a_next     = corner_vec(3'd0).a;
                            b_next     = corner_vec(3'd0).b;
                            cin_next   = corner_vec(3'd0).cin;
                        end
                    end
                end

                CORNER: begin
                    if (xfer) begin
                        idx_next = vec_idx + 32'd1;
                        if (vec_idx == LAST_IDX) begin
                            state_next = DONE;
                            valid_next = 1'b0;
                            busy_next  = 1'b0;
                            done_next  = 1'b1;
                        end else if (vec_idx == LAST_CORNER) begin
                            state_next = FILL;
                            valid_next = 1'b0;
                            fill_next  = '0;
                        end else begin
                            a_next   = cv.a;
                            b_next   = cv.b;
                            cin_next = cv.cin;
                        end
                    end
                end

                FILL: begin
                    // Each step shifts one fresh word in at the bottom. The first word ends up in the MSBs of a.
                    lfsr_next = word;
                    if (fill_cnt == FILL_LAST) begin
                        a_next     = shift[2*N-1:N];
                        b_next     = shift[N-1:0];
                        cin_next   = word[0];
                        valid_next = 1'b1;
                        state_next = PRESENT;
                    end else begin
                        shift_next = {shift[2*N-33:0], word};
                        fill_next  = fill_cnt + FW'(1);
                    end
                end

                PRESENT: begin
                    if (xfer) begin
                        idx_next   = vec_idx + 32'd1;
                        valid_next = 1'b0;
                        if (vec_idx == LAST_IDX) begin
                            state_next = DONE;
                            busy_next  = 1'b0;
                            done_next  = 1'b1;
                        end else begin
                            state_next = FILL;
                            fill_next  = '0;
                        end
                    end
                end

                DONE: begin
                    valid_next = 1'b0;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end

                default: state_next = IDLE;
            endcase
        end
    end

    // State, LFSR, fill datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            lfsr     <= 32'd1;
            shift    <= '0;
            fill_cnt <= '0;
            valid    <= 1'b0;
            a        <= '0;
            b        <= '0;
            cin      <= 1'b0;
            vec_idx  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every register here samples pre-edge values.
            state    <= state_next;
            lfsr     <= lfsr_next;
            shift    <= shift_next;
            fill_cnt <= fill_next;
            valid    <= valid_next;
            a        <= a_next;
            b        <= b_next;
            cin      <= cin_next;
            vec_idx  <= idx_next;
            busy     <= busy_next;
            done     <= done_next;
        end
    end

endmodule
